// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/write-back stage with req/ack data-memory port and register-file write.
// Optional forwarding outputs are enabled by defining MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              reg_we_in,
  input  logic              load_en_in,
  input  logic              mem_re_in,
  input  logic              mem_we_in,
  input  logic [A_SIZE-1:0] addr_in,
  input  logic [D_SIZE-1:0] wdata_in,
  input  logic [D_SIZE-1:0] result_in,
  input  logic [2:0]        dest_reg_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [A_SIZE-1:0] dmem_addr,
  output logic [D_SIZE-1:0] dmem_wdata,
  input  logic [D_SIZE-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [D_SIZE-1:0] rf_wdata,
  output logic              err
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [2:0]        fwd_reg,
  output logic [D_SIZE-1:0] fwd_data,
  output logic              fwd_pending,
  output logic [2:0]        fwd_pend_reg
`endif
);
  typedef enum logic {IDLE, MEM} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, rf_we_q, rf_we_d, err_q, err_d;
  logic rwe_q, rwe_d, lden_q, lden_d, wr_q, wr_d;
  logic [A_SIZE-1:0] addr_q, addr_d;
  logic [D_SIZE-1:0] wdata_q, wdata_d, rf_wdata_q, rf_wdata_d, res_q, res_d;
  logic [2:0] rf_waddr_q, rf_waddr_d, dest_q, dest_d;
  logic accept, mem_op, done;
  assign accept = in_valid && state_q == IDLE;
  // load_en without a read has no memory source, so it falls back to a plain result write
  assign mem_op = mem_re_in || (mem_we_in && !load_en_in);
  assign done   = state_q == MEM && dmem_ack;
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rwe_d      = rwe_q;
    lden_d     = lden_q;
    wr_d       = wr_q;
    dest_d     = dest_q;
    res_d      = res_q;
    err_d      = err_q | (accept && ((mem_re_in && mem_we_in) || (load_en_in && !mem_re_in)));
    if (accept && !mem_op) begin
      rf_we_d    = reg_we_in;
      rf_waddr_d = dest_reg_in;
      rf_wdata_d = result_in;
    end
    if (accept && mem_op) begin
      state_d = MEM;
      req_d   = 1'b1;
      we_d    = mem_we_in && !mem_re_in;
      wr_d    = mem_we_in && !mem_re_in;
      addr_d  = addr_in;
      wdata_d = wdata_in;
      rwe_d   = reg_we_in;
      lden_d  = load_en_in;
      dest_d  = dest_reg_in;
      res_d   = result_in;
    end
    if (done) begin
      state_d    = IDLE;
      req_d      = 1'b0;
      rf_we_d    = rwe_q && !wr_q;
      rf_waddr_d = wr_q ? rf_waddr_q : dest_q;
      rf_wdata_d = wr_q ? rf_wdata_q : (lden_q ? dmem_rdata : res_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      rwe_q      <= 1'b0;
      lden_q     <= 1'b0;
      wr_q       <= 1'b0;
      dest_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      rwe_q      <= rwe_d;
      lden_q     <= lden_d;
      wr_q       <= wr_d;
      dest_q     <= dest_d;
      res_q      <= res_d;
    end
  end
  assign stall      = state_q == MEM;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign err        = err_q;
`ifdef MEM_WB_FWD_EN
  logic pend_q;
  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else pend_q <= (accept && mem_op) ? reg_we_in : (done ? 1'b0 : pend_q);
  end
  assign fwd_valid    = rf_we_q;
  assign fwd_reg      = rf_waddr_q;
  assign fwd_data     = rf_wdata_q;
  assign fwd_pending  = pend_q;
  assign fwd_pend_reg = dest_q;
`else
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed stimulus with a queue scoreboard checked by a register-file write monitor.
module tb_mem_wb_stage;
  logic clk = 1'b0, rst;
  logic in_valid, reg_we_in, load_en_in, mem_re_in, mem_we_in;
  logic [9:0] addr_in;
  logic [31:0] wdata_in, result_in, dmem_rdata, rf_wdata, dmem_wdata;
  logic [2:0] dest_reg_in, rf_waddr;
  logic stall, dmem_req, dmem_we, dmem_ack, rf_we, err;
  logic [9:0] dmem_addr;
  typedef struct {logic [2:0] r; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .reg_we_in(reg_we_in), .load_en_in(load_en_in),
    .mem_re_in(mem_re_in), .mem_we_in(mem_we_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .result_in(result_in), .dest_reg_in(dest_reg_in), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [2:0] r, input logic [31:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic drive(input logic re, input logic we, input logic ld, input logic rwe,
                       input logic [2:0] dst, input logic [9:0] a, input logic [31:0] wd, input logic [31:0] res);
    in_valid = 1'b1; mem_re_in = re; mem_we_in = we; load_en_in = ld; reg_we_in = rwe;
    dest_reg_in = dst; addr_in = a; wdata_in = wd; result_in = res;
  endtask
  task automatic idle_in();
    in_valid = 1'b0; mem_re_in = 1'b0; mem_we_in = 1'b0; load_en_in = 1'b0; reg_we_in = 1'b0;
  endtask
  task automatic alu(input logic [2:0] dst, input logic [31:0] res, input logic ld);
    drive(1'b0, 1'b0, ld, 1'b1, dst, 10'h0, 32'h0, res);
    push(dst, res);
    step();
    idle_in();
    chk("alu_stall", stall, 0);
    step();
  endtask
  task automatic memop(input logic re, input logic we, input logic ld, input logic rwe, input logic [2:0] dst,
                       input logic [9:0] a, input logic [31:0] wd, input logic [31:0] rd, input int n, input logic exp_we);
    drive(re, we, ld, rwe, dst, a, wd, 32'h0BAD_0BAD);
    step();
    idle_in();
    for (int i = 0; i < n; i++) begin
      chk("req_high", dmem_req, 1);
      chk("stall_high", stall, 1);
      chk("dmem_addr", dmem_addr, a);
      chk("dmem_we", dmem_we, exp_we);
      if (exp_we) chk("dmem_wdata", dmem_wdata, wd);
      if (i == n - 1) begin
        dmem_ack = 1'b1;
        dmem_rdata = rd;
      end
      step();
      dmem_ack = 1'b0;
    end
    chk("req_low", dmem_req, 0);
    chk("stall_low", stall, 0);
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rf_we === 1'b1) begin
          if (exp_q.size() == 0) chk("rf_we_unexpected", rf_we, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rf_waddr", rf_waddr, e.r);
            chk("rf_wdata", rf_wdata, e.d);
          end
        end
      end
    join_none
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; addr_in = '0; wdata_in = '0; result_in = '0; dest_reg_in = '0;
    idle_in();
    step();
    step();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    alu(3'd3, 32'h0000_0012, 1'b0);
    push(3'd2, 32'hDEAD_BEEF);
    memop(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 10'h005, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    memop(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 10'h3FF, 32'hA5A5_A5A5, 32'h0, 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 10'h0, 32'h0, 32'h0000_0111);
    push(3'd1, 32'h0000_0111);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 10'h020, 32'h0, 32'h0);
    push(3'd4, 32'h1234_5678);
    step();
    chk("b2b_stall", stall, 1);
    chk("b2b_req", dmem_req, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 10'h0, 32'h0, 32'h0000_0555);
    push(3'd5, 32'h0000_0555);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    chk("b2b_stall_wb", stall, 0);
    chk("b2b_req_wb", dmem_req, 0);
    step();
    idle_in();
    chk("b2b_stall_end", stall, 0);
    step();
    chk("err_clean", err, 0);
    push(3'd6, 32'hCAFE_F00D);
    memop(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 10'h010, 32'h1111_1111, 32'hCAFE_F00D, 2, 1'b0);
    chk("err_set", err, 1);
    alu(3'd0, 32'h0000_00AB, 1'b0);
    chk("err_sticky", err, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 10'h033, 32'h0, 32'h0);
    step();
    idle_in();
    chk("abort_req_before", dmem_req, 1);
    step();
    rst = 1'b1;
    step();
    chk("abort_req", dmem_req, 0);
    chk("abort_stall", stall, 0);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_err", err, 0);
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h7777_7777;
    step();
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", stall, 0);
    step();
    step();
    alu(3'd7, 32'h0000_0042, 1'b1);
    chk("loadc_err", err, 1);
    step();
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Takes execute results and memory controls, runs a req/ack transaction on the data memory for loads and stores, and drives the register-file write port.
- Stalls the upstream pipeline while a memory transaction is outstanding.
- Register writes come from the ALU/loadc result for non-memory ops and from memory read data for loads.

Parameters:
D_SIZE, 32, data width of results, memory data and register-file data
A_SIZE, 10, data-memory address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  execute stage presents an instruction this cycle
reg_we_in  input  1  instruction writes the register file
load_en_in  input  1  register write data comes from memory (load)
mem_re_in  input  1  memory read request
mem_we_in  input  1  memory write request
addr_in  input  A_SIZE  memory address
wdata_in  input  D_SIZE  store data
result_in  input  D_SIZE  ALU/loadc result
dest_reg_in  input  3  destination register index
stall  output  1  upstream must hold all inputs stable while high
dmem_req  output  1  data-memory request, held until ack
dmem_we  output  1  1 = write, 0 = read; valid with dmem_req
dmem_addr  output  A_SIZE  memory address; stable while dmem_req is high
dmem_wdata  output  D_SIZE  store data; stable while dmem_req is high
dmem_rdata  input  D_SIZE  read data; valid in the ack cycle
dmem_ack  input  1  one-cycle transaction completion pulse
rf_we  output  1  register-file write strobe, one cycle
rf_waddr  output  3  register-file write index
rf_wdata  output  D_SIZE  register-file write data
err  output  1  sticky protocol-error flag

Behaviour:
- All outputs registered except stall, which decodes state.
- Reset (synchronous) values: state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, err=0.
- Reset mid-transaction aborts: dmem_req is low the cycle after the reset edge, the pending register write is discarded, and no rf_we is produced.
- stall = (state == MEM).
- An instruction is accepted when in_valid && !stall.
- States: IDLE, MEM.
- IDLE, accept, non-memory op (mem_re_in=0, mem_we_in=0):
  - Stay in IDLE.
  - Next cycle: rf_we=reg_we_in, rf_waddr=dest_reg_in, rf_wdata=result_in.
  - Latency 1; one instruction accepted per cycle.
- IDLE, accept, memory op:
  - Capture dest_reg_in, reg_we_in, load_en_in and the operation type.
  - Next cycle: state=MEM, dmem_req=1, dmem_we=mem_we_in&&!mem_re_in, dmem_addr=addr_in, dmem_wdata=wdata_in.
- Both mem_re_in and mem_we_in set: the op is treated as a read, the write is dropped, and err is set to 1.
- MEM:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held constant until dmem_ack.
  - dmem_ack is ignored when dmem_req=0.
- Ack cycle:
  - Next cycle: dmem_req=0 and state=IDLE.
  - Read: rf_we=captured reg_we, rf_waddr=captured dest_reg, rf_wdata = dmem_rdata sampled in the ack cycle if load_en was set, otherwise the captured result.
  - Write: rf_we=0.
- Minimum memory op: accept at t, req at t+1, ack at t+1, rf write and IDLE at t+2, next accept at t+2.
- Ack can arrive any number of cycles after req; there is no timeout.
- rf_we is never high for two consecutive cycles from the same instruction.
- rf_we=0 in every cycle with no completing instruction; rf_waddr and rf_wdata hold their last values.
- load_en_in=1 with mem_re_in=0: treated as a non-memory op, rf_wdata=result_in, err set.
- err clears only on rst.

Optional Feature:
- Macro MEM_WB_FWD_EN.
- When defined, add outputs:
  - fwd_valid (1): equals rf_we.
  - fwd_reg (3): equals rf_waddr.
  - fwd_data (D_SIZE): equals rf_wdata.
  - fwd_pending (1): high in MEM when the captured reg_we=1, so the operand-read stage stalls on a dest_reg match.
  - fwd_pend_reg (3): the captured dest_reg.
- All forwarding outputs reset to 0.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid ADD: result_in=0x0000_0012, dest_reg_in=3, reg_we_in=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12; stall stays 0.
- Load: addr_in=0x05, dest 2, ack returned 3 cycles after req with dmem_rdata=0xDEAD_BEEF -> dmem_req high exactly 3 cycles with addr 0x05, stall high for the same 3 cycles, one cycle after the ack rf_we=1, rf_waddr=2, rf_wdata=0xDEADBEEF.
- Store: addr 0x3FF, wdata_in=0xA5A5_A5A5, ack in the same cycle as req -> dmem_we=1 for one cycle, no rf_we, stall for 1 cycle.
- Back-to-back ADD, load (ack immediate), ADD -> rf writes in order with a one-cycle bubble for the load; the second ADD is accepted the cycle the load writes back.
- mem_re_in=1 and mem_we_in=1 -> read issued, dmem_we=0, err=1 and held through later traffic until rst.
- rst asserted while dmem_req=1 -> next cycle dmem_req=0, stall=0, no rf_we; a late dmem_ack after reset causes no effect.
